// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and result bus for serial_add_ctrl.
// SERIAL_ADD_OVF_EN adds the two's-complement overflow flag ovf.
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::SA_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADD_OVF_EN
    modport master (output start, a, b, ci, input busy, done, sum, co, ovf);
    modport slave  (input start, a, b, ci, output busy, done, sum, co, ovf);
`else
    modport master (output start, a, b, ci, input busy, done, sum, co);
    modport slave  (input start, a, b, ci, output busy, done, sum, co);
`endif

endinterface

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder cell shared by the serial datapath.
module fa_bit (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic Y,
    output logic Co
);

    assign Y  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: {co,sum} = a + b + ci, LSB first, one bit per clock.
// Optional SERIAL_ADD_OVF_EN registers the two's-complement overflow flag with co.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [WIDTH-1:0] sum_r;
    logic             co_r;
    logic             busy_r;
    logic             done_r;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    fa_bit u_fa (
        .A  (a_sh[0]),
        .B  (b_sh[0]),
        .Ci (carry),
        .Y  (fa_s),
        .Co (fa_c)
    );

    assign last_bit = (count == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            co_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.ci;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_r <= {fa_s, sum_r[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    count <= count + 1'b1;
                    if (last_bit) begin
                        co_r   <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        // carry here is the carry into the MSB position
                        ovf_r  <= carry ^ fa_c;
`endif
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.co   = co_r;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule
